// File: rtl/fadd_pipe.sv
// Pipelined FP add/sub (FTZ, round-to-nearest-even) with special values and exception flags.
// Latency 3 cycles at 1 result/cycle; a held output (out_valid & !out_ready) freezes every stage.
module fadd_pipe #(
    parameter  int EW = 8,
    parameter  int MW = 23,
    localparam int W  = 1 + EW + MW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         flag_nv,
    output logic         flag_of,
    output logic         flag_nx
);
    localparam int AW = MW + 3;     // hidden + mantissa + guard + round
    localparam int SW = AW + 2;     // plus sticky and carry
    localparam int XW = EW + 2;     // signed exponent headroom
    localparam logic [EW-1:0] EMAX = '1;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---------------- S1: unpack, specials, align ----------------
    logic            sa, sb, za, zb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EW-1:0]   ea, eb, el, es;
    logic [MW-1:0]   ma, mb;
    logic [EW+MW-1:0] mag_a, mag_b;
    logic [MW:0]     fl, fs;
    logic [31:0]     sh;
    logic [2*AW-1:0] wide;
    logic [AW:0]     c1_ml, c1_ms;
    logic            c1_spec, c1_spec_nv;
    logic [W-1:0]    c1_spec_y;

    always_comb begin
        sa    = x1[W-1];
        ea    = x1[W-2:MW];
        ma    = x1[MW-1:0];
        sb    = x2[W-1] ^ op;
        eb    = x2[W-2:MW];
        mb    = x2[MW-1:0];
        a_nan = (ea == EMAX) && (ma != '0);
        b_nan = (eb == EMAX) && (mb != '0);
        a_inf = (ea == EMAX) && (ma == '0);
        b_inf = (eb == EMAX) && (mb == '0);
        za    = (ea == '0);
        zb    = (eb == '0);
        mag_a = za ? '0 : {ea, ma};
        mag_b = zb ? '0 : {eb, mb};
        swap  = mag_b > mag_a;
        el    = swap ? eb : ea;
        es    = swap ? ea : eb;
        fl    = swap ? (zb ? '0 : {1'b1, mb}) : (za ? '0 : {1'b1, ma});
        fs    = swap ? (za ? '0 : {1'b1, ma}) : (zb ? '0 : {1'b1, mb});
        sh    = 32'(el) - 32'(es);
        if (sh > 32'(AW))
            sh = 32'(AW);
        // Everything shifted into the low half collapses into the sticky bit.
        wide  = {fs, 2'b00, {AW{1'b0}}} >> sh;
        c1_ml = {fl, 3'b000};
        c1_ms = {wide[2*AW-1:AW], |wide[AW-1:0]};

        c1_spec    = 1'b0;
        c1_spec_nv = 1'b0;
        c1_spec_y  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            c1_spec    = 1'b1;
            c1_spec_nv = 1'b1;
            c1_spec_y  = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};
        end else if (a_inf) begin
            c1_spec   = 1'b1;
            c1_spec_y = {sa, EMAX, {MW{1'b0}}};
        end else if (b_inf) begin
            c1_spec   = 1'b1;
            c1_spec_y = {sb, EMAX, {MW{1'b0}}};
        end
    end

    logic          s1_vld, s1_spec, s1_spec_nv, s1_sub, s1_sign, s1_zsign;
    logic [W-1:0]  s1_spec_y;
    logic [EW-1:0] s1_exp;
    logic [AW:0]   s1_ml, s1_ms;

    logic          s2_vld, s2_spec, s2_spec_nv, s2_sign, s2_zsign;
    logic [W-1:0]  s2_spec_y;
    logic [EW-1:0] s2_exp;
    logic [SW-1:0] s2_sum;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_spec    <= c1_spec;
            s1_spec_nv <= c1_spec_nv;
            s1_spec_y  <= c1_spec_y;
            s1_sub     <= (sa != sb);
            s1_sign    <= swap ? sb : sa;
            s1_zsign   <= sa && sb;
            s1_exp     <= el;
            s1_ml      <= c1_ml;
            s1_ms      <= c1_ms;

            // ---------------- S2: magnitude add/subtract ----------------
            s2_spec    <= s1_spec;
            s2_spec_nv <= s1_spec_nv;
            s2_spec_y  <= s1_spec_y;
            s2_sign    <= s1_sign;
            s2_zsign   <= s1_zsign;
            s2_exp     <= s1_exp;
            s2_sum     <= s1_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms})
                                 : ({1'b0, s1_ml} + {1'b0, s1_ms});
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [XW-1:0] lz, xn, xf;
    logic [AW:0]   nrm;
    logic [MW:0]   mr;
    logic          g, r, st, rup;
    logic [W-1:0]  c3_y;
    logic          c3_nv, c3_of, c3_nx;

    always_comb begin
        lz = '0;
        for (int i = 0; i <= AW; i++)
            if (s2_sum[i])
                lz = XW'(AW - i);
        if (s2_sum[SW-1]) begin
            nrm = {s2_sum[AW+1:2], s2_sum[1] | s2_sum[0]};
            xn  = XW'(s2_exp) + XW'(1);
        end else begin
            nrm = s2_sum[AW:0] << lz;
            xn  = XW'(s2_exp) - lz;
        end
        g   = nrm[2];
        r   = nrm[1];
        st  = nrm[0];
        rup = g && (r || st || nrm[3]);
        mr  = {1'b0, nrm[AW-1:3]} + (MW+1)'(rup);
        xf  = xn + XW'(mr[MW]);

        c3_y  = '0;
        c3_nv = 1'b0;
        c3_of = 1'b0;
        c3_nx = 1'b0;
        if (s2_spec) begin
            c3_y  = s2_spec_y;
            c3_nv = s2_spec_nv;
        end else if (!nrm[AW]) begin
            c3_y = {s2_zsign, {(W-1){1'b0}}};
        end else if (xn[XW-1] || (xn == '0)) begin
            c3_y  = {s2_sign, {(W-1){1'b0}}};
            c3_nx = 1'b1;
        end else if (xf >= XW'(EMAX)) begin
            c3_y  = {s2_sign, EMAX, {MW{1'b0}}};
            c3_of = 1'b1;
            c3_nx = 1'b1;
        end else begin
            c3_y  = {s2_sign, xf[EW-1:0], mr[MW-1:0]};
            c3_nx = g || r || st;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            flag_nv   <= 1'b0;
            flag_of   <= 1'b0;
            flag_nx   <= 1'b0;
        end else if (en) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (s2_vld) begin
                y       <= c3_y;
                flag_nv <= c3_nv;
                flag_of <= c3_of;
                flag_nx <= c3_nx;
            end else begin
                flag_nv <= 1'b0;
                flag_of <= 1'b0;
                flag_nx <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed scoreboard bench for fadd_pipe (binary32): latency, rounding, specials, stalls, reset.
module tb_fadd_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        flag_nv, flag_of, flag_nx;

    fadd_pipe #(.EW(8), .MW(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flag_nv(flag_nv), .flag_of(flag_of), .flag_nx(flag_nx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] y;
        logic [2:0]  f;   // {nv, of, nx}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] fint(input int n);
        case (n)
            1: return 32'h3F800000;
            2: return 32'h40000000;
            3: return 32'h40400000;
            4: return 32'h40800000;
            5: return 32'h40A00000;
            6: return 32'h40C00000;
            7: return 32'h40E00000;
            8: return 32'h41000000;
            9: return 32'h41100000;
            default: return 32'h00000000;
        endcase
    endfunction

    // Leaves in_valid asserted so consecutive calls stream back-to-back.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o,
                        input logic [31:0] ey, input logic [2:0] ef);
        bit done = 1'b0;
        x1 = a; x2 = b; op = o; in_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
        end
        if (done) sb.push_back('{ey, ef});
        chk("send_accept", 64'(done), 64'(1));
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        chk("drain", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Output monitor: scoreboard pop, idle flags, stall behaviour.
    logic        held = 1'b0;
    logic [34:0] held_val;
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_pending", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 64'({y, flag_nv, flag_of, flag_nx}), 64'({e.y, e.f}));
                end
            end
            if (!out_valid)
                chk("flags_idle", 64'({flag_nv, flag_of, flag_nx}), 64'(0));
            if (out_valid && !out_ready) begin
                chk("in_ready_stall", 64'(in_ready), 64'(0));
                if (held) chk("y_hold", 64'({y, flag_nv, flag_of, flag_nx}), 64'(held_val));
                held     = 1'b1;
                held_val = {y, flag_nv, flag_of, flag_nx};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_y", 64'(y), 64'(0));
        chk("rst_flags", 64'({flag_nv, flag_of, flag_nx}), 64'(0));
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // 1 + 2 = 3 with exact three-cycle latency
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        in_valid = 1'b0;
        @(negedge clk); chk("lat_c1", 64'(out_valid), 64'(0));
        @(negedge clk); chk("lat_c2", 64'(out_valid), 64'(0));
        @(negedge clk); chk("lat_c3", 64'(out_valid), 64'(1));
        drain();

        // Directed arithmetic, rounding and special cases, streamed
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);
        send(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 3'b000);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001);
        send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 3'b000);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000);
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3'b000);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        send(32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100);
        send(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000);
        send(32'hFF800000, 32'hFF800000, 1'b0, 32'hFF800000, 3'b000);
        send(32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001);
        drain();

        // Back-to-back stream with a five-cycle output stall
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send(fint(i), 32'h3F800000, 1'b0, fint(i + 1), 3'b000);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three results in flight: nothing may emerge afterwards
        out_ready = 1'b0;
        send(fint(1), fint(1), 1'b0, fint(2), 3'b000);
        send(fint(2), fint(1), 1'b0, fint(3), 3'b000);
        send(fint(3), fint(1), 1'b0, fint(4), 3'b000);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_flush_valid", 64'(out_valid), 64'(0));
        chk("rst_flush_y", 64'(y), 64'(0));
        chk("rst_flush_in_ready", 64'(in_ready), 64'(1));
        repeat (10) @(posedge clk);
        #1;

        // Pipeline must still work after the mid-flight reset
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
